x2_vec_drv: RTL and testbench

- Sequential stimulus/response stage wrapped around the combinational x2 netlist (inputs a..j, outputs k..q).
- Generates pseudo-random 10-bit input vectors with an LFSR and holds each one for a settle window, which models ReRAM NOR-chain evaluation latency.
- Compacts every sampled 7-bit response into a 16-bit MISR signature.
- At the end of a run, compares the signature against a golden value and reports pass/fail to the host.

---
 rtl/x2_vec_drv.sv | 155 +++++++++++++++
 tb/tb_x2_vec_drv.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/x2_vec_drv.sv
// Purpose: LFSR vector driver and MISR response compactor around the x2 netlist, with golden-signature pass/fail.
// Latency: each vector is held SETTLE+1 cycles; done rises num_vec*(SETTLE+1) cycles after the start edge.
// Backpressure: none; start is ignored while busy, and the response is sampled unconditionally on the sample cycle.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, num_vec, seed, golden  run request and its parameters (captured on start)
//   vec_out, vec_valid            stimulus to x2 ([9]=a .. [0]=j) and its live flag
//   resp_in                       x2 response ([6]=k .. [0]=q)
//   busy, done, pass              run status; pass is meaningful only while done=1
//   signature, vec_cnt            current MISR value and vectors sampled so far
module x2_vec_drv #(
    parameter int          SETTLE    = 2,
    parameter logic [15:0] MISR_INIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] num_vec,
    input  logic [9:0]  seed,
    input  logic [15:0] golden,
    output logic [9:0]  vec_out,
    output logic        vec_valid,
    input  logic [6:0]  resp_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [15:0] vec_cnt
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [9:0]  vec_q;
    logic        vld_q;
    logic [3:0]  settle_cnt;
    logic [15:0] misr_q;
    logic [15:0] cnt_q;
    logic [15:0] num_q;
    logic [15:0] golden_q;

    logic        start_ok;
    logic        sample;
    logic        last;
    logic [9:0]  seed_eff;
    logic [9:0]  lfsr_nxt;
    logic [15:0] misr_nxt;

    // A start request is honoured only outside a run.
    assign start_ok = start && (state != ST_RUN);
    assign sample   = (state == ST_RUN) && (settle_cnt == SETTLE_LAST);
    // cnt_q < num_q <= 65535 while running, so the +1 cannot overflow.
    assign last     = sample && ((cnt_q + 16'd1) == num_q);

    // An all-zero seed would lock the LFSR, so it is replaced by 001.
    assign seed_eff = (seed == 10'd0) ? 10'h001 : seed;
    // Fibonacci LFSR, x^10 + x^7 + 1.
    assign lfsr_nxt = {vec_q[8:0], vec_q[9] ^ vec_q[6]};
    assign misr_nxt = ({misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'h002D : 16'h0000))
                      ^ {9'b0, resp_in};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = (num_vec == 16'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; pass follows the registered final signature.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: begin
                done = 1'b1;
                pass = (misr_q == golden_q);
            end
            default: ;
        endcase
    end

    // Datapath: vector generator, settle timer, MISR and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q      <= 10'd0;
            vld_q      <= 1'b0;
            settle_cnt <= 4'd0;
            misr_q     <= MISR_INIT;
            cnt_q      <= 16'd0;
            num_q      <= 16'd0;
            golden_q   <= 16'd0;
        end else if (start_ok) begin
            num_q      <= num_vec;
            golden_q   <= golden;
            misr_q     <= MISR_INIT;
            cnt_q      <= 16'd0;
            settle_cnt <= 4'd0;
            vld_q      <= (num_vec != 16'd0);
            if (num_vec != 16'd0) begin
                vec_q <= seed_eff;
            end
        end else if (state == ST_RUN) begin
            if (sample) begin
                misr_q     <= misr_nxt;
                cnt_q      <= cnt_q + 16'd1;
                settle_cnt <= 4'd0;
                if (last) begin
                    // Final vector stays on vec_out, but is no longer live.
                    vld_q <= 1'b0;
                end else begin
                    vec_q <= lfsr_nxt;
                end
            end else begin
                settle_cnt <= settle_cnt + 4'd1;
            end
        end
    end

    assign vec_out   = vec_q;
    assign vec_valid = vld_q;
    assign signature = misr_q;
    assign vec_cnt   = cnt_q;

endmodule

// File: tb/tb_x2_vec_drv.sv
module tb_x2_vec_drv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] num_vec;
    logic [9:0]  seed;
    logic [15:0] golden;

    logic [9:0]  vec_out_a, vec_out_b;
    logic        vec_valid_a, vec_valid_b;
    logic [6:0]  resp_a, resp_b;
    logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [15:0] sig_a, sig_b, cnt_a, cnt_b;

    logic        resp_mode;   // 1: constant response, 0: surrogate of x2
    logic [6:0]  resp_const;

    int checks = 0;
    int errors = 0;

    // Stand-in for the x2 netlist: any fixed function of the vector will do.
    function automatic logic [6:0] x2_surrogate(input logic [9:0] v);
        return v[6:0] ^ {4'b0, v[9:7]} ^ 7'h55;
    endfunction

    assign resp_a = resp_mode ? resp_const : x2_surrogate(vec_out_a);
    assign resp_b = x2_surrogate(vec_out_b);

    x2_vec_drv #(.SETTLE(2), .MISR_INIT(16'hFFFF)) dut_a (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .seed(seed),
        .golden(golden), .vec_out(vec_out_a), .vec_valid(vec_valid_a),
        .resp_in(resp_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .signature(sig_a), .vec_cnt(cnt_a)
    );

    x2_vec_drv #(.SETTLE(0), .MISR_INIT(16'hFFFF)) dut_b (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .seed(seed),
        .golden(golden), .vec_out(vec_out_b), .vec_valid(vec_valid_b),
        .resp_in(resp_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .signature(sig_b), .vec_cnt(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [9:0] model_q[$];
    logic [9:0] obs_q[$];

    task automatic model_run(input logic [9:0] sd, input int n, input logic mode,
                             input logic [6:0] cst, output logic [15:0] sig,
                             output logic [9:0] last_vec);
        int l;
        int m;
        int r;
        model_q.delete();
        l = (sd == 0) ? 1 : int'(sd);
        m = 'hFFFF;
        last_vec = 10'(l);
        for (int i = 0; i < n; i++) begin
            model_q.push_back(10'(l));
            last_vec = 10'(l);
            r = mode ? int'(cst) : int'(x2_surrogate(10'(l)));
            m = ((m * 2) % 65536) ^ ((m >= 'h8000) ? 'h2D : 0) ^ r;
            l = ((l * 2) % 1024) + (((l / 512) + (l / 64)) % 2);
        end
        sig = 16'(m);
    endtask

    // Starts a run on dut_a and waits for done. obs_q gets vec_out for every
    // live cycle. poke >= 0 pulses a disturbing start at that run cycle.
    task automatic run_a(input logic [9:0] sd, input int n, input logic [15:0] gld,
                         input int poke, output int cycles);
        obs_q.delete();
        seed = sd;
        num_vec = 16'(n);
        golden = gld;
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        while (!done_a && cycles < 4000) begin
            if (vec_valid_a) obs_q.push_back(vec_out_a);
            if (cycles == poke) begin
                start = 1'b1;
                seed = ~sd;
                num_vec = 16'(n + 7);
                golden = ~gld;
            end else begin
                start = 1'b0;
                seed = sd;
                num_vec = 16'(n);
                golden = gld;
            end
            tick();
            cycles++;
        end
        start = 1'b0;
        if (!done_a) check("run_timeout", 32'(cycles), 32'(n * 3));
    endtask

    // Checks everything about a finished dut_a run against model + expectations.
    task automatic check_run(input string tag, input int n, input int cycles,
                             input logic [15:0] exp_sig, input logic exp_pass,
                             input logic [9:0] exp_last);
        logic seq_ok;
        check({tag, "_sig"}, 32'(sig_a), 32'(exp_sig));
        check({tag, "_pass"}, 32'(pass_a), 32'(exp_pass));
        check({tag, "_done"}, 32'({done_a, busy_a, vec_valid_a}), 32'b100);
        check({tag, "_cnt"}, 32'(cnt_a), 32'(n));
        check({tag, "_cycles"}, 32'(cycles), 32'(n * 3));
        seq_ok = (obs_q.size() == n * 3);
        for (int i = 0; i < obs_q.size() && seq_ok; i++)
            if (obs_q[i] !== model_q[i / 3]) seq_ok = 1'b0;
        check({tag, "_vecseq"}, 32'(seq_ok), 32'd1);
        if (n > 0) check({tag, "_last"}, 32'(vec_out_a), 32'(exp_last));
    endtask

    typedef struct {
        logic [9:0]  sd;
        int          n;
        logic        mode;
        logic [6:0]  cst;
        logic [15:0] gld;
        logic [15:0] exp_sig;
        logic        exp_pass;
        logic [9:0]  exp_last;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int          cyc;
        logic [15:0] msig;
        logic [9:0]  mlast;
        logic [15:0] g;

        tbl[0] = '{10'h000, 3, 1'b1, 7'h00, 16'h0000, 16'hFF3B, 1'b0, 10'h004};
        tbl[1] = '{10'h001, 1, 1'b1, 7'h6F, 16'hFFBC, 16'hFFBC, 1'b1, 10'h001};
        tbl[2] = '{10'h001, 1, 1'b1, 7'h6F, 16'hFFBD, 16'hFFBC, 1'b0, 10'h001};
        tbl[3] = '{10'h005, 0, 1'b1, 7'h00, 16'hFFFF, 16'hFFFF, 1'b1, 10'h000};
        tbl[4] = '{10'h005, 0, 1'b1, 7'h00, 16'hFFFE, 16'hFFFF, 1'b0, 10'h000};
        tbl[5] = '{10'h000, 3, 1'b1, 7'h00, 16'hFF3B, 16'hFF3B, 1'b1, 10'h004};

        rst = 1'b1;
        start = 1'b0;
        num_vec = 16'd0;
        seed = 10'd0;
        golden = 16'd0;
        resp_mode = 1'b1;
        resp_const = 7'h00;

        // Reset held 3 cycles, then released.
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_flags", 32'({busy_a, done_a, pass_a, vec_valid_a}), 32'h0);
        check("rst_sig", 32'(sig_a), 32'hFFFF);
        check("rst_cnt_vec", 32'({cnt_a, 6'b0, vec_out_a}), 32'h0);

        // First-vector signature with a zero response.
        seed = 10'h000; num_vec = 16'd3; golden = 16'h0; resp_const = 7'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("first_vec_sig", 32'(sig_a), 32'hFFD3);
        check("first_vec_next", 32'(vec_out_a), 32'h002);
        repeat (10) tick();

        // Table-driven runs.
        for (int i = 0; i < 6; i++) begin
            resp_mode = tbl[i].mode;
            resp_const = tbl[i].cst;
            model_run(tbl[i].sd, tbl[i].n, tbl[i].mode, tbl[i].cst, msig, mlast);
            run_a(tbl[i].sd, tbl[i].n, tbl[i].gld, -1, cyc);
            check_run($sformatf("tbl%0d", i), tbl[i].n, cyc, tbl[i].exp_sig,
                      tbl[i].exp_pass, tbl[i].exp_last);
            check($sformatf("tbl%0d_model", i), 32'(msig), 32'(tbl[i].exp_sig));
            repeat (2) tick();
            check($sformatf("tbl%0d_hold", i), 32'({done_a, pass_a}),
                  32'({1'b1, tbl[i].exp_pass}));
        end

        // Randomized runs against the model using the x2 surrogate response.
        resp_mode = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic [9:0] sd;
            int         n;
            sd = 10'($urandom_range(0, 1023));
            n  = $urandom_range(1, 40);
            model_run(sd, n, 1'b0, 7'h0, msig, mlast);
            g = ($urandom_range(0, 1) == 1) ? msig : 16'($urandom);
            run_a(sd, n, g, -1, cyc);
            check_run($sformatf("rnd%0d", i), n, cyc, msig, (g == msig), mlast);
        end

        // A start pulse mid-run must not disturb the run.
        model_run(10'h155, 10, 1'b0, 7'h0, msig, mlast);
        run_a(10'h155, 10, msig, 4, cyc);
        check_run("midstart", 10, cyc, msig, 1'b1, mlast);

        // Reset at vec_cnt=5 abandons the run.
        seed = 10'h0AA; num_vec = 16'd20; golden = 16'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (cnt_a != 16'd5 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("rst_mid_reach5", 32'(cnt_a), 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_flags", 32'({busy_a, vec_valid_a, done_a, pass_a}), 32'h0);
        check("rst_mid_cnt", 32'(cnt_a), 32'h0);
        check("rst_mid_sig", 32'(sig_a), 32'hFFFF);
        check("rst_mid_vec", 32'(vec_out_a), 32'h0);
        tick();
        model_run(10'h0AA, 20, 1'b0, 7'h0, msig, mlast);
        run_a(10'h0AA, 20, msig, -1, cyc);
        check_run("after_rst", 20, cyc, msig, 1'b1, mlast);

        // Full LFSR period on the SETTLE=0 instance: vector 1024 equals vector 1.
        obs_q.delete();
        seed = 10'h001; num_vec = 16'd1024; golden = 16'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done_b && cyc < 2000) begin
            if (vec_valid_b) obs_q.push_back(vec_out_b);
            tick();
            cyc++;
        end
        check("period_cycles", 32'(cyc), 32'd1024);
        check("period_nvec", 32'(obs_q.size()), 32'd1024);
        if (obs_q.size() == 1024) begin
            check("period_vec1024", 32'(obs_q[1023]), 32'h001);
            check("period_vec1023", 32'(obs_q[1022]), 32'(obs_q[1021]) * 2 % 1024
                  + (32'(obs_q[1021][9] ^ obs_q[1021][6])));
        end
        check("period_cnt", 32'(cnt_b), 32'd1024);
        check("period_flags", 32'({done_b, busy_b, vec_valid_b}), 32'b100);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
